ft245_bus_scheduler: RTL
========================

Name: ft245_bus_scheduler

Overview:
- Sequences and arbitrates the half-duplex FT245 asynchronous FIFO bus between two internal requesters.
- The RX sink receives host bytes; the TX source sends bytes to the host.
- Generates the rx_245/wr_245 strobes, bus-drive enable and all setup/pulse/recovery timing. Sits between the FT245 pins at top_level and the protocol logic.

Parameters:
RD_PULSE_CYC, 3, cycles rx_245 is held low; in_245 is sampled on the last of them (60 ns at 50 MHz)
WR_SETUP_CYC, 1, cycles out_245 is driven with wr_245 low before the write strobe
WR_PULSE_CYC, 3, cycles wr_245 is held high
RECOVERY_CYC, 3, idle cycles after any transfer before the next arbitration; must be >= 3 to cover 2-flop flag sync latency
MAX_BURST, 4, max consecutive bytes in one direction while the other direction is eligible

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
in_245  in  8  FT245 data bus, read path
out_245  out  8  FT245 data bus, write path
tx_oe_245  out  1  1 = FPGA drives the data bus
rxf_245  in  1  FT245 RXF#, low = byte available (asynchronous)
rx_245  out  1  FT245 RD#, active low
txe_245  in  1  FT245 TXE#, low = space available (asynchronous)
wr_245  out  1  FT245 WR, active high; FT245 latches data on the falling edge
rx_data  out  8  received byte
rx_valid  out  1  one-cycle pulse, rx_data valid
rx_ready  in  1  sink can take a byte
tx_data  in  8  byte to send
tx_valid  in  1  source has a byte
tx_ready  out  1  one-cycle pulse; tx_data is consumed this cycle
busy  out  1  state != IDLE

Behaviour:
- Reset values: rx_245=1, wr_245=0, tx_oe_245=0, out_245=0, rx_data=0, rx_valid=0, tx_ready=0, burst_cnt=0, last_dir=RX, state=IDLE.
- rxf_245 and txe_245 pass through 2-flop synchronizers (rxf_s, txe_s); reset value of each stage is 1.
- Eligibility, evaluated only in IDLE:
  - rx_el = !rxf_s && rx_ready
  - tx_el = !txe_s && tx_valid
- Arbitration:
  - Only one direction eligible: take it.
  - Both eligible: take last_dir if burst_cnt < MAX_BURST, else the other direction.
  - burst_cnt increments on a same-direction grant and reloads to 1 on a direction switch. Saturates at MAX_BURST.
  - Neither eligible: stay in IDLE.
- States: IDLE, RD_PULSE, WR_SETUP, WR_PULSE, WR_HOLD, RECOVER.
- Read path: IDLE -> RD_PULSE.
  - rx_245=0 for RD_PULSE_CYC cycles.
  - On the final cycle, in_245 is registered into rx_data and rx_valid pulses the next cycle, together with rx_245 returning to 1.
  - Then -> RECOVER.
- Write path: IDLE -> WR_SETUP.
  - On the grant cycle tx_ready=1; tx_data is registered into out_245 and tx_oe_245 goes to 1.
  - WR_SETUP lasts WR_SETUP_CYC cycles, then WR_PULSE holds wr_245=1 for WR_PULSE_CYC cycles.
  - WR_HOLD is 1 cycle with wr_245=0 and tx_oe_245 still 1 (data hold past the falling edge).
  - Then -> RECOVER with tx_oe_245=0.
- RECOVER: RECOVERY_CYC cycles with all strobes inactive, then -> IDLE. This gives the synchronizers time to show the updated RXF#/TXE#.
- Invariants:
  - rx_245=0 and tx_oe_245=1 never occur together.
  - tx_oe_245 falls at least RECOVERY_CYC cycles before any rx_245 fall.
  - Exactly one rx_valid per rx_245 low pulse; exactly one tx_ready per wr_245 pulse.
- Flag changes during a transfer are ignored; a transfer in progress always completes.
- rx_ready or tx_valid dropping after the grant has no effect on the transfer in progress.
- Reset mid-transfer: all outputs take their reset values asynchronously. A byte partly read is discarded, and rx_valid is not issued for it.

Decomposition:
- inc/project_defines.v gains the FT245 state-code defines and default timing constants (RD_PULSE_CYC, WR_*, RECOVERY_CYC, MAX_BURST).
- One sub-module: ft245_flag_sync, a 2-flop synchronizer with reset-to-1, instantiated for rxf_245 and txe_245.
- Timing counters and the arbiter stay inline.

Test Plan:
1. Reset, then rxf_245=0 with in_245=0xAA and rx_ready=1 -> rx_245 low for exactly 3 cycles (60 ns) starting 3 cycles after rxf falls; rx_valid pulses once with rx_data=0xAA. With rxf_245 back to 1 by then, there is no second read.
2. txe_245=0, tx_valid=1, tx_data=0x5A, rxf_245=1 -> tx_ready pulses once. out_245=0x5A with tx_oe_245=1; wr_245 high 3 cycles after 1 setup cycle; tx_oe_245 held 1 cycle after wr_245 falls.
3. rxf_245 and txe_245 both held low, rx_ready=1, tx_valid=1 -> transfer order is RX×4, TX×4, RX×4; rx_245 low never overlaps tx_oe_245=1.
4. rxf_245=0 with rx_ready=0 -> rx_245 stays 1 indefinitely. Raising rx_ready starts a read within 2 cycles.
5. Assert rst during the 2nd cycle of RD_PULSE -> rx_245 returns to 1 in the same cycle without waiting for a clock edge. No rx_valid is issued; after release the byte is re-read normally.
6. txe_245=1 with tx_valid=1 -> tx_ready never pulses and wr_245 stays 0. Dropping txe_245 to 0 lets the write proceed.

Source files
------------

// File: rtl/ft245_bus_scheduler_pkg.sv
// Shared types and default timing for the FT245 bus scheduler.
// Timing defaults assume a 50 MHz system clock.
package ft245_bus_scheduler_pkg;

    localparam int RD_PULSE_CYC_DEF = 3;
    localparam int WR_SETUP_CYC_DEF = 1;
    localparam int WR_PULSE_CYC_DEF = 3;
    localparam int RECOVERY_CYC_DEF = 3;
    localparam int MAX_BURST_DEF    = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_PULSE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RECOVER
    } state_t;

    typedef enum logic {
        DIR_RX = 1'b0,
        DIR_TX = 1'b1
    } dir_t;

    // Stick with the last direction until its burst quota is used up.
    function automatic dir_t pick_dir(
        input logic rx_el,
        input logic tx_el,
        input dir_t last,
        input logic under_cap
    );
        dir_t d;
        if (rx_el && tx_el) begin
            if (under_cap) begin
                d = last;
            end else if (last == DIR_RX) begin
                d = DIR_TX;
            end else begin
                d = DIR_RX;
            end
        end else if (tx_el) begin
            d = DIR_TX;
        end else begin
            d = DIR_RX;
        end
        return d;
    endfunction

endpackage

// File: rtl/ft245_flag_sync.sv
// Two-flop synchronizer for the FT245 status flags.
// Resets to 1 so an unsynchronized flag reads as "not ready".
module ft245_flag_sync (
    input  logic clk,
    input  logic rst,
    input  logic flag,
    output logic sync
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= flag;
            sync <= meta;
        end
    end

endmodule

// File: rtl/ft245_bus_scheduler.sv
// Arbitrates the half-duplex FT245 FIFO bus between an RX sink and a TX source
// and generates all strobe, bus-drive and recovery timing.
module ft245_bus_scheduler
    import ft245_bus_scheduler_pkg::*;
#(
    parameter int RD_PULSE_CYC = RD_PULSE_CYC_DEF,
    parameter int WR_SETUP_CYC = WR_SETUP_CYC_DEF,
    parameter int WR_PULSE_CYC = WR_PULSE_CYC_DEF,
    parameter int RECOVERY_CYC = RECOVERY_CYC_DEF,
    parameter int MAX_BURST    = MAX_BURST_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_245,
    output logic [7:0] out_245,
    output logic       tx_oe_245,
    input  logic       rxf_245,
    output logic       rx_245,
    input  logic       txe_245,
    output logic       wr_245,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy
);

    localparam int CW = 8;
    localparam int BW = $clog2(MAX_BURST + 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [BW-1:0] burst_cnt;
    dir_t          last_dir;
    dir_t          grant_dir;
    logic          rxf_s;
    logic          txe_s;
    logic          rx_el;
    logic          tx_el;
    logic          grant;
    logic          rd_done;

    ft245_flag_sync u_rxf_sync (
        .clk  (clk),
        .rst  (rst),
        .flag (rxf_245),
        .sync (rxf_s)
    );

    ft245_flag_sync u_txe_sync (
        .clk  (clk),
        .rst  (rst),
        .flag (txe_245),
        .sync (txe_s)
    );

    assign rx_el     = !rxf_s && rx_ready;
    assign tx_el     = !txe_s && tx_valid;
    assign grant     = (state == IDLE) && (rx_el || tx_el);
    assign grant_dir = pick_dir(rx_el, tx_el, last_dir,
                                burst_cnt < BW'(MAX_BURST));
    assign tx_ready  = grant && (grant_dir == DIR_TX);
    assign rd_done   = (state == RD_PULSE) && (state_next == RECOVER);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    if (grant_dir == DIR_TX) begin
                        state_next = WR_SETUP;
                    end else begin
                        state_next = RD_PULSE;
                    end
                end
            end
            RD_PULSE: begin
                if (cnt == CW'(RD_PULSE_CYC - 1)) state_next = RECOVER;
            end
            WR_SETUP: begin
                if (cnt == CW'(WR_SETUP_CYC - 1)) state_next = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt == CW'(WR_PULSE_CYC - 1)) state_next = WR_HOLD;
            end
            WR_HOLD: begin
                state_next = RECOVER;
            end
            RECOVER: begin
                if (cnt == CW'(RECOVERY_CYC - 1)) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
            last_dir  <= DIR_RX;
        end else if (grant) begin
            last_dir <= grant_dir;
            if (grant_dir != last_dir) begin
                burst_cnt <= BW'(1);
            end else if (burst_cnt != BW'(MAX_BURST)) begin
                burst_cnt <= burst_cnt + BW'(1);
            end
        end
    end

    // Pin strobes are registered from the next state to keep them glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_245    <= 1'b1;
            wr_245    <= 1'b0;
            tx_oe_245 <= 1'b0;
            out_245   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            rx_245    <= (state_next != RD_PULSE);
            wr_245    <= (state_next == WR_PULSE);
            tx_oe_245 <= (state_next == WR_SETUP) ||
                         (state_next == WR_PULSE) ||
                         (state_next == WR_HOLD);
            rx_valid  <= rd_done;
            if (rd_done) rx_data <= in_245;
            if (tx_ready) out_245 <= tx_data;
        end
    end

endmodule
